// File: rtl/oled_spi_writer.sv
// OLED 4-wire SPI byte writer: accepts a 10-bit request (D/C + byte) and shifts it out
// MSB first in SPI mode 3, returning a one-cycle WRITE_DONE once CS_N is released.
module oled_spi_writer #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       WRITE_START,
   input  logic [9:0] DATA,
   output logic       WRITE_DONE,
   output logic       BUSY,
   output logic       SCLK,
   output logic       MOSI,
   output logic       CS_N,
   output logic       DC
);
   localparam int unsigned DIV_W = 16;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      RELEASE
   } state_t;

   state_t           state, state_next;
   logic [DIV_W-1:0] div, div_next;
   logic [2:0]       bit_cnt, bit_next;
   logic [7:0]       shreg, shreg_next;
   logic             sclk_next, mosi_next, cs_n_next, dc_next, done_next;
   logic             div_end;
   logic             unused_data;

   assign div_end     = (div == DIV_LAST);
   assign unused_data = DATA[9];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         div        <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         SCLK       <= 1'b1;
         MOSI       <= 1'b0;
         CS_N       <= 1'b1;
         DC         <= 1'b0;
         WRITE_DONE <= 1'b0;
         BUSY       <= 1'b0;
      end else begin
         state      <= state_next;
         div        <= div_next;
         bit_cnt    <= bit_next;
         shreg      <= shreg_next;
         SCLK       <= sclk_next;
         MOSI       <= mosi_next;
         CS_N       <= cs_n_next;
         DC         <= dc_next;
         WRITE_DONE <= done_next;
         BUSY       <= (state_next != IDLE);
      end
   end

   always_comb begin
      state_next = state;
      div_next   = div;
      bit_next   = bit_cnt;
      shreg_next = shreg;
      sclk_next  = SCLK;
      mosi_next  = MOSI;
      cs_n_next  = CS_N;
      dc_next    = DC;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (WRITE_START) begin
               shreg_next = DATA[7:0];
               dc_next    = DATA[8];
               cs_n_next  = 1'b0;
               mosi_next  = DATA[7];
               div_next   = '0;
               bit_next   = 3'd7;
               state_next = SETUP;
            end
         end
         SETUP: begin
            if (div_end) begin
               div_next   = '0;
               sclk_next  = 1'b0;
               mosi_next  = shreg[bit_cnt];
               state_next = SHIFT;
            end else begin
               div_next = div + DIV_W'(1);
            end
         end
         // Each bit: low half then high half; MOSI only moves on the falling edge.
         SHIFT: begin
            if (!div_end) begin
               div_next = div + DIV_W'(1);
            end else begin
               div_next = '0;
               if (!SCLK) begin
                  sclk_next = 1'b1;
               end else if (bit_cnt == 3'd0) begin
                  state_next = HOLD;
               end else begin
                  bit_next  = bit_cnt - 3'd1;
                  sclk_next = 1'b0;
                  mosi_next = shreg[bit_cnt - 3'd1];
               end
            end
         end
         HOLD: begin
            if (div_end) begin
               div_next   = '0;
               cs_n_next  = 1'b1;
               done_next  = 1'b1;
               state_next = RELEASE;
            end else begin
               div_next = div + DIV_W'(1);
            end
         end
         // Wait for the initiator to drop its request so it is not re-accepted.
         RELEASE: begin
            if (!WRITE_START) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_oled_spi_writer.sv
// Bench for oled_spi_writer: table-driven writes on a CLK_DIV=4 instance with a
// scoreboard monitor on the SPI pins, plus reset/abort and CLK_DIV=1 sequences.
module tb_oled_spi_writer;
   logic clk = 1'b0;
   logic rst;
   logic start4, start1;
   logic [9:0] data4, data1;
   logic done4, busy4, sclk4, mosi4, cs_n4, dc4;
   logic done1, busy1, sclk1, mosi1, cs_n1, dc1;

   always #5 clk = ~clk;

   oled_spi_writer #(.CLK_DIV(4)) dut4 (
      .CLK(clk), .RST(rst), .WRITE_START(start4), .DATA(data4),
      .WRITE_DONE(done4), .BUSY(busy4), .SCLK(sclk4), .MOSI(mosi4), .CS_N(cs_n4), .DC(dc4)
   );

   oled_spi_writer #(.CLK_DIV(1)) dut1 (
      .CLK(clk), .RST(rst), .WRITE_START(start1), .DATA(data1),
      .WRITE_DONE(done1), .BUSY(busy1), .SCLK(sclk1), .MOSI(mosi1), .CS_N(cs_n1), .DC(dc1)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [9:0] data;
      logic       exp_dc;
      logic [7:0] exp_byte;
      int         extra_hold;
      int         change_at;
   } vec_t;

   vec_t       tbl[7];
   logic [8:0] sb_q[$];
   int         n_pushed = 0;
   int         n_done   = 0;

   // Monitor: capture MOSI on every SCLK rise, score the byte when WRITE_DONE fires.
   int         cyc = 0, t_acc = 0, nbits = 0, cs_hi = 100;
   logic       in_xfer = 1'b0, prev_cs = 1'b1, prev_sclk = 1'b1, dc_cap = 1'b0;
   logic [7:0] cap;
   logic [8:0] exp_item;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         in_xfer = 1'b0;
         nbits   = 0;
      end else begin
         if (prev_cs && !cs_n4) begin
            check("cs_gap_ge2", 32'(cs_hi >= 2), 32'd1);
            in_xfer = 1'b1;
            t_acc   = cyc;
            nbits   = 0;
            cap     = 8'h00;
            dc_cap  = dc4;
         end
         if (in_xfer && !prev_sclk && sclk4) begin
            cap = {cap[6:0], mosi4};
            nbits++;
            check("cs_low_at_rise", 32'(cs_n4), 32'd0);
         end
         if (done4) begin
            n_done++;
            if (sb_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_item = sb_q.pop_front();
               check("byte", 32'(cap), 32'(exp_item[7:0]));
               check("dc", 32'(dc_cap), 32'(exp_item[8]));
               check("rise_count", 32'(nbits), 32'd8);
               check("latency", 32'(cyc - t_acc), 32'd72);
               check("cs_high_at_done", 32'(cs_n4), 32'd1);
               check("sclk_idle_at_done", 32'(sclk4), 32'd1);
            end
            in_xfer = 1'b0;
         end
      end
      cs_hi     = cs_n4 ? cs_hi + 1 : 0;
      prev_cs   = cs_n4;
      prev_sclk = sclk4;
   end

   task automatic do_write(input logic [9:0] d, input logic edc, input logic [7:0] eb,
                           input int extra, input int change_at);
      int  n;
      bit  got;
      start4 = 1'b1;
      data4  = d;
      sb_q.push_back({edc, eb});
      n_pushed++;
      n   = 0;
      got = 1'b0;
      while (n < 400 && !got) begin
         @(negedge clk);
         n++;
         if (change_at > 0 && n == change_at) data4 = ~d;
         if (done4) got = 1'b1;
      end
      check("done_timeout", 32'(got), 32'd1);
      @(posedge clk);
      repeat (extra) @(posedge clk);
      #1;
      if (extra > 0) begin
         check("busy_while_held", 32'(busy4), 32'd1);
         check("cs_high_while_held", 32'(cs_n4), 32'd1);
      end
      start4 = 1'b0;
      @(posedge clk);
      #1;
      check("idle_after_drop", 32'(busy4), 32'd0);
      check("dc_holds", 32'(dc4), 32'(edc));
   endtask

   int   n, rises, last_rise, t1;
   logic ps, pcs;
   bit   got1;

   initial begin
      tbl[0] = '{10'h0AE, 1'b0, 8'hAE, 0, 0};
      tbl[1] = '{10'h1A5, 1'b1, 8'hA5, 0, 0};
      tbl[2] = '{10'h3A5, 1'b1, 8'hA5, 0, 0};
      tbl[3] = '{10'h0AE, 1'b0, 8'hAE, 0, 0};
      tbl[4] = '{10'h081, 1'b0, 8'h81, 0, 0};
      tbl[5] = '{10'h0FF, 1'b0, 8'hFF, 5, 0};
      tbl[6] = '{10'h0C3, 1'b0, 8'hC3, 0, 30};

      rst    = 1'b1;
      start4 = 1'b1;
      data4  = 10'h1AE;
      start1 = 1'b0;
      data1  = 10'h000;
      @(negedge clk);
      check("rst_sclk", 32'(sclk4), 32'd1);
      check("rst_cs_n", 32'(cs_n4), 32'd1);
      check("rst_mosi", 32'(mosi4), 32'd0);
      check("rst_dc", 32'(dc4), 32'd0);
      check("rst_done", 32'(done4), 32'd0);
      check("rst_busy", 32'(busy4), 32'd0);
      repeat (3) @(negedge clk);
      check("rst_no_xfer", 32'(cs_n4), 32'd1);
      start4 = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++)
         do_write(tbl[i].data, tbl[i].exp_dc, tbl[i].exp_byte, tbl[i].extra_hold, tbl[i].change_at);

      // Abort a transfer with reset after the third SCLK rise.
      start4 = 1'b1;
      data4  = 10'h0F0;
      rises  = 0;
      n      = 0;
      ps     = sclk4;
      while (n < 200 && rises < 3) begin
         @(negedge clk);
         n++;
         if (!ps && sclk4) rises++;
         ps = sclk4;
      end
      check("abort_reach_rise3", 32'(rises), 32'd3);
      #2 rst = 1'b1;
      #1;
      check("abort_sclk", 32'(sclk4), 32'd1);
      check("abort_cs_n", 32'(cs_n4), 32'd1);
      check("abort_mosi", 32'(mosi4), 32'd0);
      check("abort_dc", 32'(dc4), 32'd0);
      check("abort_busy", 32'(busy4), 32'd0);
      start4 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      do_write(10'h087, 1'b0, 8'h87, 0, 0);

      // CLK_DIV=1 instance: 2-cycle SCLK period, done 18 cycles after acceptance.
      start1    = 1'b1;
      data1     = 10'h0FF;
      n         = 0;
      rises     = 0;
      last_rise = 0;
      t1        = 0;
      got1      = 1'b0;
      ps        = sclk1;
      pcs       = cs_n1;
      while (n < 100 && !got1) begin
         @(negedge clk);
         n++;
         if (pcs && !cs_n1) t1 = n;
         if (!ps && sclk1) begin
            rises++;
            check("div1_mosi", 32'(mosi1), 32'd1);
            if (rises > 1) check("div1_period", 32'(n - last_rise), 32'd2);
            last_rise = n;
         end
         if (done1) got1 = 1'b1;
         ps  = sclk1;
         pcs = cs_n1;
      end
      check("div1_done_timeout", 32'(got1), 32'd1);
      check("div1_latency", 32'(n - t1), 32'd18);
      check("div1_rises", 32'(rises), 32'd8);
      @(posedge clk);
      #1 start1 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("div1_idle", 32'(busy1), 32'd0);

      repeat (10) @(negedge clk);
      check("transfer_count", 32'(n_done), 32'(n_pushed));
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
